// File: rtl/ex_mem_skid_reg.sv
// EX->MEM elastic pipeline register: two-entry skid buffer with a registered in_ready.
// Optional EX_MEM_STATS_EN adds saturating transfer/stall counters.
module ex_mem_skid_reg #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_wen,
  output logic [1:0]        occupancy
`ifdef EX_MEM_STATS_EN
  ,
  output logic [31:0]       stat_xfer,
  output logic [31:0]       stat_stall
`endif
);

  // state   | meaning
  // S_EMPTY | nothing held, outputs invalid
  // S_ONE   | main register holds the oldest word
  // S_TWO   | main and skid both full, upstream stalled
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              drain;
  logic [DATA_W-1:0] skid_data;
  logic [TAG_W-1:0]  skid_tag;
  logic              skid_wen;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // in_ready is a flop so there is no combinational path from out_ready back to EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != S_TWO);
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (accept) state_nxt = S_ONE;
        S_ONE: begin
          if (accept && !drain)      state_nxt = S_TWO;
          else if (!accept && drain) state_nxt = S_EMPTY;
        end
        S_TWO:   if (drain) state_nxt = S_ONE;
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state)
      S_ONE: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      S_TWO: begin
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_tag   <= '0;
      out_wen   <= 1'b0;
      skid_data <= '0;
      skid_tag  <= '0;
      skid_wen  <= 1'b0;
    end else if (flush) begin
      out_wen  <= 1'b0;
      skid_wen <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            out_data <= in_data;
            out_tag  <= in_tag;
            out_wen  <= in_wen;
          end
        end
        S_ONE: begin
          if (accept && drain) begin
            out_data <= in_data;
            out_tag  <= in_tag;
            out_wen  <= in_wen;
          end else if (accept) begin
            skid_data <= in_data;
            skid_tag  <= in_tag;
            skid_wen  <= in_wen;
          end
        end
        S_TWO: begin
          if (drain) begin
            out_data  <= skid_data;
            out_tag   <= skid_tag;
            out_wen   <= skid_wen;
            skid_data <= '0;
            skid_tag  <= '0;
            skid_wen  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef EX_MEM_STATS_EN
  // a drain in a flush cycle is squashed, so it is not a transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_xfer  <= '0;
      stat_stall <= '0;
    end else begin
      if (drain && !flush && (stat_xfer != 32'hFFFF_FFFF))
        stat_xfer <= stat_xfer + 32'd1;
      if (out_valid && !out_ready && (stat_stall != 32'hFFFF_FFFF))
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Bench for ex_mem_skid_reg: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ex_mem_skid_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [4:0]  in_tag = '0;
  logic        in_wen = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [4:0]  out_tag;
  logic        out_wen;
  logic [1:0]  occupancy;
`ifdef EX_MEM_STATS_EN
  logic [31:0] stat_xfer;
  logic [31:0] stat_stall;
`endif

  ex_mem_skid_reg #(.DATA_W(64), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_tag(in_tag), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_wen(out_wen),
    .occupancy(occupancy)
`ifdef EX_MEM_STATS_EN
    , .stat_xfer(stat_xfer), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [4:0]  t;
    logic        w;
  } word_t;

  word_t       mq[$];
  bit          rst_zero = 1'b0;
  bit          wen_zero = 1'b0;
  bit          chk_en = 1'b1;
  logic [31:0] e_xfer = '0;
  logic [31:0] e_stall = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a FIFO of at most two words; ready whenever fewer than two are held
  always @(posedge clk or negedge rst_n) begin : model
    bit acc;
    if (!rst_n) begin
      mq.delete();
      rst_zero = 1'b1;
      wen_zero = 1'b0;
      e_xfer = '0;
      e_stall = '0;
    end else begin
      acc = in_valid && (mq.size() < 2);
      if (mq.size() > 0 && !out_ready) e_stall++;
      if (flush) begin
        mq.delete();
        wen_zero = 1'b1;
      end else begin
        if (mq.size() > 0 && out_ready) begin
          void'(mq.pop_front());
          if (e_xfer != 32'hFFFF_FFFF) e_xfer++;
        end
        if (acc) begin
          mq.push_back({in_data, in_tag, in_wen});
          rst_zero = 1'b0;
          wen_zero = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    word_t w;
    if (chk_en && rst_n) begin
      chk("out_valid", out_valid, 64'(mq.size() > 0));
      chk("in_ready", in_ready, 64'(mq.size() < 2));
      chk("occupancy", occupancy, 64'(mq.size()));
      if (mq.size() > 0) begin
        w = mq[0];
        chk("out_data", out_data, w.d);
        chk("out_tag", out_tag, 64'(w.t));
        chk("out_wen", out_wen, 64'(w.w));
      end else begin
        if (rst_zero) begin
          chk("idle_data", out_data, 64'd0);
          chk("idle_tag", out_tag, 64'd0);
        end
        if (rst_zero || wen_zero) chk("idle_wen", out_wen, 64'd0);
      end
`ifdef EX_MEM_STATS_EN
      chk("stat_xfer", stat_xfer, 64'(e_xfer));
      chk("stat_stall", stat_stall, 64'(e_stall));
`endif
    end
  end

  task automatic step(input logic v, input logic [63:0] d, input logic [4:0] t,
                      input logic w, input logic r, input logic f);
    #1;
    in_valid = v; in_data = d; in_tag = t; in_wen = w; out_ready = r; flush = f;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit acc;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 64'd0);
    chk("rst_in_ready", in_ready, 64'd1);
    chk("rst_occupancy", occupancy, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_wen", out_wen, 64'd0);
    #8 rst_n = 1'b1;
    @(negedge clk);

    // single word, latency 1
    step(1, 64'h0123_4567_89AB_CDEF, 5'd3, 1, 1, 0);
    chk("t1_valid", out_valid, 64'd1);
    chk("t1_data", out_data, 64'h0123_4567_89AB_CDEF);
    chk("t1_tag", out_tag, 64'd3);
    chk("t1_occ", occupancy, 64'd1);
    step(0, 64'd0, 5'd0, 0, 1, 0);
    chk("t1_drained", out_valid, 64'd0);

    // streaming at full rate
    for (int i = 0; i < 8; i++) begin
      step(1, 64'(i + 1), 5'(i), 1, 1, 0);
      chk("stream_data", out_data, 64'(i + 1));
      chk("stream_in_ready", in_ready, 64'd1);
    end
    step(0, 64'd0, 5'd0, 0, 1, 0);
    chk("stream_empty", occupancy, 64'd0);

    // back-pressure: A, B fill both entries, C held upstream
    step(1, 64'hAAAA, 5'd1, 1, 0, 0);
    step(1, 64'hBBBB, 5'd2, 0, 0, 0);
    chk("bp_occ2", occupancy, 64'd2);
    chk("bp_in_ready0", in_ready, 64'd0);
    chk("bp_head_a", out_data, 64'hAAAA);
    step(1, 64'hCCCC, 5'd3, 1, 0, 0);
    chk("bp_hold_occ", occupancy, 64'd2);
    step(1, 64'hCCCC, 5'd3, 1, 1, 0);
    chk("bp_out_b", out_data, 64'hBBBB);
    chk("bp_out_b_wen", out_wen, 64'd0);
    step(1, 64'hCCCC, 5'd3, 1, 1, 0);
    chk("bp_out_c", out_data, 64'hCCCC);
    chk("bp_occ1", occupancy, 64'd1);
    step(0, 64'd0, 5'd0, 0, 1, 0);
    chk("bp_empty", occupancy, 64'd0);

    // flush while full, with accept and drain attempted in the same cycle
    step(1, 64'hAAAA, 5'd1, 1, 0, 0);
    step(1, 64'hBBBB, 5'd2, 1, 0, 0);
    step(1, 64'hDDDD, 5'd4, 1, 1, 1);
    chk("fl_occ", occupancy, 64'd0);
    chk("fl_valid", out_valid, 64'd0);
    chk("fl_wen", out_wen, 64'd0);
    chk("fl_in_ready", in_ready, 64'd1);
    step(0, 64'd0, 5'd0, 0, 1, 0);
    chk("fl_d_dropped", out_valid, 64'd0);

    // async reset while in TWO, between edges
    step(1, 64'h1111, 5'd5, 1, 0, 0);
    step(1, 64'h2222, 5'd6, 1, 0, 0);
    chk("ar_occ2", occupancy, 64'd2);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 64'd0);
    chk("ar_in_ready", in_ready, 64'd1);
    chk("ar_occ", occupancy, 64'd0);
    chk("ar_data", out_data, 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // randomized traffic; upstream holds a word until it is accepted
    acc = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = {$urandom, $urandom};
        in_tag   = 5'($urandom);
        in_wen   = 1'($urandom);
      end
      case ((c / 250) % 4)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) == 0);
        default: out_ready = ($urandom_range(0, 1) == 0);
      endcase
      flush = ($urandom_range(0, 40) == 0);
      acc = in_valid && (mq.size() < 2);
      @(posedge clk);
      @(negedge clk);
    end
    idle();
    step(0, 64'd0, 5'd0, 0, 1, 0);
    step(0, 64'd0, 5'd0, 0, 1, 0);

`ifdef EX_MEM_STATS_EN
    // 4 stall cycles and 3 transfers after a fresh reset
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    step(1, 64'h5, 5'd1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 64'd0, 5'd0, 0, 0, 0);
    step(0, 64'd0, 5'd0, 0, 1, 0);
    step(1, 64'h6, 5'd2, 1, 1, 0);
    step(0, 64'd0, 5'd0, 0, 1, 0);
    step(1, 64'h7, 5'd3, 1, 1, 0);
    step(0, 64'd0, 5'd0, 0, 1, 0);
    chk("st_xfer3", stat_xfer, 64'd3);
    chk("st_stall4", stat_stall, 64'd4);
    chk_en = 1'b0;
    #1 force dut.stat_xfer = 32'hFFFF_FFFF;
    #1 release dut.stat_xfer;
    @(negedge clk);
    step(1, 64'h8, 5'd4, 1, 1, 0);
    step(0, 64'd0, 5'd0, 0, 1, 0);
    chk("st_sat", stat_xfer, 64'h0000_0000_FFFF_FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
- Elastic pipeline register between the EX-stage 64-bit operand/result select and the MEM stage of the pipelined datapath.
- Captures the selected 64-bit value with its destination register tag and write-enable.
- Two-entry skid buffer with valid/ready handshake on both sides, so MEM-stage back-pressure never drops or duplicates a result.
- in_ready is driven from a register, which breaks the combinational ready path back into EX.

Parameters:
- DATA_W, 64, width of the data word taken from the 2:1 select output.
- TAG_W, 5, width of the destination register index.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of all held entries (branch/exception).
- in_valid  input  1  upstream word present.
- in_ready  output  1  block can accept this cycle; registered.
- in_data  input  DATA_W  selected value from the EX select stage.
- in_tag  input  TAG_W  destination register index.
- in_wen  input  1  register-file write enable carried with the word.
- out_valid  output  1  word presented to MEM.
- out_ready  input  1  MEM accepts this cycle.
- out_data  output  DATA_W  held value.
- out_tag  output  TAG_W  held destination index.
- out_wen  output  1  held write enable.
- occupancy  output  2  number of entries held: 0, 1 or 2.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_tag=0, out_wen=0, in_ready=1, occupancy=0, skid entry cleared. These values hold until the first clk edge after rst_n deasserts.
- Handshakes:
  - Accept occurs when in_valid&&in_ready.
  - Drain occurs when out_valid&&out_ready.
  - Once out_valid is asserted, out_data, out_tag and out_wen stay stable until drained or flushed.
- Storage: main register (drives outputs) plus one skid register. FSM states: EMPTY, ONE, TWO. occupancy equals 0, 1 or 2 respectively.
- EMPTY:
  - Accept -> ONE; the word appears on the outputs the next cycle (latency 1).
  - out_ready is ignored.
- ONE:
  - Accept with no drain -> TWO; the new word goes to skid.
  - Drain with no accept -> EMPTY.
  - Accept and drain in the same cycle -> stays ONE; the main register loads the new word. This sustains full throughput of one word per cycle.
- TWO:
  - in_ready=0, so no accept is possible.
  - Drain -> ONE; skid moves to main and skid clears.
  - No drain -> holds.
- in_ready is registered and equals (next_state != TWO). Upstream data presented while in_ready=0 is ignored and must be held by upstream.
- Ordering: strictly FIFO; skid never bypasses main.
- flush:
  - Next state is EMPTY, out_valid=0, in_ready=1.
  - An accept or drain in the flush cycle is discarded.
  - flush has priority over every other event.
  - Data/tag registers need not clear on flush; out_wen is forced to 0.
- in_wen=0 words are still carried and handshaked normally; the block does not filter them.
- No arithmetic: data, tag and wen pass bit-exact.

Optional Feature:
- Macro: EX_MEM_STATS_EN.
- When defined, adds outputs stat_xfer[31:0] and stat_stall[31:0].
  - stat_xfer counts drain cycles.
  - stat_stall counts cycles with out_valid=1 and out_ready=0.
  - Both counters saturate at 32'hFFFFFFFF, clear on reset, and do not clear on flush.
- When undefined, neither the ports nor the counters exist. Core behaviour is identical in both cases.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> outputs zero immediately, in_ready=1, occupancy=0. Drive in_valid=1, data=64'h0123_4567_89AB_CDEF, tag=5'd3 for 1 cycle with out_ready=1 -> out_valid=1 the next cycle with the same data/tag, then drained.
- Streaming: 8 back-to-back words 1..8 with out_ready=1 constantly -> 8 outputs on 8 consecutive cycles, order 1..8, in_ready never drops.
- Back-pressure: out_ready=0 while sending A=64'hAAAA, B=64'hBBBB -> occupancy=2, in_ready=0 the cycle after B, C held upstream. Then out_ready=1 -> outputs A, B, C in order, with no loss or duplicate.
- Flush: occupancy=2, assert flush with in_valid=1 (D) and out_ready=1 in the same cycle -> next cycle occupancy=0, out_valid=0, out_wen=0, D not captured, A not counted as drained.
- Async reset mid-operation: rst_n pulled low while in state TWO between clock edges -> out_valid=0 and in_ready=1 immediately, with no edge required.
- EX_MEM_STATS_EN build: 3 transfers and 4 stall cycles -> stat_xfer=3, stat_stall=4. Force stat_xfer to 32'hFFFFFFFF and do one more transfer -> it stays at 32'hFFFFFFFF.
